// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base with a two-digit BCD seconds counter (00..MAX_TENS9).
// Raw start/stop and clear buttons are synchronised, debounced and edge-detected.
module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DEB_CYC  = 1_000_000,
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] diZ,
  output logic [3:0] diU,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYC - 1);
  localparam logic [3:0]    TENS_LAST  = 4'(MAX_TENS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // bit 0 = start/stop, bit 1 = clear
  logic [1:0]         meta_q, meta_d;
  logic [1:0]         sync_q, sync_d;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         dly_q, dly_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic               ss_p, clr_p;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [3:0]         diz_q, diz_d;
  logic [3:0]         diu_q, diu_d;
  logic               running_q, running_d;
  logic               wrap_q, wrap_d;
  logic               tick;

  // Stage 0: synchronise, debounce, edge-detect
  always_comb begin
    meta_d = {btn_clr, btn_ss};
    sync_d = meta_q;
    dly_d  = deb_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign ss_p  = deb_q[0] & ~dly_q[0];
  assign clr_p = deb_q[1] & ~dly_q[1];

  // Stage 1: control FSM; clear beats start/stop only when paused
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_p) state_d = RUN;
      RUN:     if (ss_p) state_d = PAUSE;
      PAUSE: begin
        if (clr_p)     state_d = IDLE;
        else if (ss_p) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // Stage 2: prescaler and BCD digits; prescaler holds in PAUSE to keep the partial second
  always_comb begin
    presc_d   = presc_q;
    diz_d     = diz_q;
    diu_d     = diu_q;
    wrap_d    = 1'b0;
    running_d = (state_d == RUN);
    if (state_d == IDLE) begin
      presc_d = '0;
      diz_d   = '0;
      diu_d   = '0;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        if (diu_q < 4'd9) begin
          diu_d = diu_q + 4'd1;
        end else begin
          diu_d = '0;
          if (diz_q < TENS_LAST) begin
            diz_d = diz_q + 4'd1;
          end else begin
            diz_d  = '0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      dly_q     <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      presc_q   <= '0;
      diz_q     <= '0;
      diu_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      diz_q     <= diz_d;
      diu_q     <= diu_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign diZ     = diz_q;
  assign diU     = diu_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
